// File: rtl/axi_lite_ctrl_slave_pkg.sv
// rtl/axi_lite_ctrl_slave_pkg.sv - register map, response codes and shared types for the tensor core control slave
package axi_lite_ctrl_slave_pkg;

    typedef logic [3:0] compute_type_t;

    localparam logic [1:0]  CTRL_IDX    = 2'd0;
    localparam logic [1:0]  STATUS_IDX  = 2'd1;
    localparam logic [1:0]  ID_IDX      = 2'd2;
    localparam logic [31:0] ID_VALUE    = 32'h7C0E_0001;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_ctrl_regs.sv
// rtl/axi_lite_ctrl_regs.sv - CTRL/STATUS/ID storage, byte-merged writes, sticky done flag and read mux
module axi_lite_ctrl_regs
    import axi_lite_ctrl_slave_pkg::*;
(
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          wr_en,
    input  logic [1:0]    wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_strb,
    input  logic [1:0]    rd_idx,
    output logic [31:0]   rd_data,
    output logic          rd_err,
    input  logic          core_busy,
    input  logic          core_done,
    output logic          start,
    output logic          mixed,
    output compute_type_t compute_type
);

    logic [5:0]  ctrl_q;
    logic        done_sticky;
    logic [31:0] ctrl_wr;
    logic        done_clr;

    assign ctrl_wr  = byte_merge({26'b0, ctrl_q}, wr_data, wr_strb);
    assign done_clr = wr_en && (wr_idx == STATUS_IDX) && wr_strb[0] && wr_data[1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_q      <= '0;
            done_sticky <= 1'b0;
        end else begin
            if (wr_en && (wr_idx == CTRL_IDX)) begin
                ctrl_q <= ctrl_wr[5:0];
            end
            // A completion in the same cycle as a clear must not be lost.
            if (core_done) begin
                done_sticky <= 1'b1;
            end else if (done_clr) begin
                done_sticky <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_idx)
            CTRL_IDX:   rd_data = {26'b0, ctrl_q};
            STATUS_IDX: rd_data = {30'b0, done_sticky, core_busy};
            ID_IDX:     rd_data = ID_VALUE;
            default:    rd_err  = 1'b1;
        endcase
    end

    assign start        = ctrl_q[0];
    assign mixed        = ctrl_q[1];
    assign compute_type = ctrl_q[5:2];

endmodule

// File: rtl/axi_lite_ctrl_slave.sv
// rtl/axi_lite_ctrl_slave.sv - AXI-Lite responder with independent write and read channel FSMs
module axi_lite_ctrl_slave
    import axi_lite_ctrl_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    input  logic                  core_busy,
    input  logic                  core_done,
    output logic                  start,
    output logic                  mixed,
    output compute_type_t         compute_type
);

    wr_state_t   wstate, wstate_n;
    rd_state_t   rstate, rstate_n;

    logic        aw_held, aw_held_n, w_held, w_held_n;
    logic [1:0]  aw_idx_q, aw_idx_n;
    logic [31:0] wdata_q, wdata_n;
    logic [3:0]  wstrb_q, wstrb_n;
    logic        awready_n, wready_n, bvalid_n;
    logic [1:0]  bresp_n;
    logic        wr_commit;

    logic        arready_n, rvalid_n;
    logic [31:0] rdata_n;
    logic [1:0]  rresp_n;
    logic [31:0] rd_data;
    logic        rd_err;

    // Write channel: AW and W are captured independently; commit once both are held.
    always_comb begin
        wstate_n  = wstate;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        aw_idx_n  = aw_idx_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        awready_n = awready;
        wready_n  = wready;
        bvalid_n  = bvalid;
        bresp_n   = bresp;
        wr_commit = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (awvalid && awready) begin
                    aw_held_n = 1'b1;
                    aw_idx_n  = awaddr[3:2];
                end
                if (wvalid && wready) begin
                    w_held_n = 1'b1;
                    wdata_n  = wdata;
                    wstrb_n  = wstrb;
                end
                awready_n = !aw_held_n;
                wready_n  = !w_held_n;
                if (aw_held_n && w_held_n) begin
                    wr_commit = 1'b1;
                    wstate_n  = W_RESP;
                    bvalid_n  = 1'b1;
                    bresp_n   = (aw_idx_n == 2'd3) ? RESP_SLVERR : RESP_OKAY;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    wstate_n  = W_IDLE;
                end
            end
            default: wstate_n = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate   <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            wstate   <= wstate_n;
            aw_held  <= aw_held_n;
            w_held   <= w_held_n;
            aw_idx_q <= aw_idx_n;
            wdata_q  <= wdata_n;
            wstrb_q  <= wstrb_n;
            awready  <= awready_n;
            wready   <= wready_n;
            bvalid   <= bvalid_n;
            bresp    <= bresp_n;
        end
    end

    // Read channel: registered response, so a read racing a write sees the old value.
    always_comb begin
        rstate_n  = rstate;
        arready_n = arready;
        rvalid_n  = rvalid;
        rdata_n   = rdata;
        rresp_n   = rresp;
        case (rstate)
            R_IDLE: begin
                arready_n = 1'b1;
                if (arvalid && arready) begin
                    rdata_n   = rd_data;
                    rresp_n   = rd_err ? RESP_SLVERR : RESP_OKAY;
                    rvalid_n  = 1'b1;
                    arready_n = 1'b0;
                    rstate_n  = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    rstate_n  = R_IDLE;
                end
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            rstate  <= rstate_n;
            arready <= arready_n;
            rvalid  <= rvalid_n;
            rdata   <= rdata_n;
            rresp   <= rresp_n;
        end
    end

    axi_lite_ctrl_regs u_regs (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .wr_en        (wr_commit),
        .wr_idx       (aw_idx_n),
        .wr_data      (wdata_n),
        .wr_strb      (wstrb_n),
        .rd_idx       (araddr[3:2]),
        .rd_data      (rd_data),
        .rd_err       (rd_err),
        .core_busy    (core_busy),
        .core_done    (core_done),
        .start        (start),
        .mixed        (mixed),
        .compute_type (compute_type)
    );

endmodule
